// File: rtl/register_file_pkg.sv
// Shared definitions for the MIPS general-purpose register file:
// register indices, program-model reset values and the index type.
package register_file_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_GP   = 5'd28;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_INIT_DEFAULT = 32'h1000_8000;

endpackage

// File: rtl/regfile_cell.sv
// One register of the file: an enabled flop with a synchronous active-low
// reset to a per-register constant.
module regfile_cell #(
    parameter int                N_BITS  = 32,
    parameter logic [N_BITS-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [N_BITS-1:0] d,
    output logic [N_BITS-1:0] q
);

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/register_file.sv
// 32 x N_BITS MIPS register file: two combinational read ports, one
// synchronous write port, hardwired $zero, $gp/$sp reset to program-model values.
module register_file
    import register_file_pkg::*;
#(
    parameter int                N_BITS      = 32,
    parameter logic [N_BITS-1:0] SP_INIT     = N_BITS'(SP_INIT_DEFAULT),
    parameter logic [N_BITS-1:0] GP_INIT     = N_BITS'(GP_INIT_DEFAULT),
    parameter bit                WRITE_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        WriteRegister,
    input  logic [N_BITS-1:0] WriteData,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    output logic [N_BITS-1:0] ReadData1,
    output logic [N_BITS-1:0] ReadData2
);

    logic [N_BITS-1:0] regs [32];

    // $zero has no storage; the read mux sees a constant.
    assign regs[REG_ZERO] = '0;

    for (genvar i = 1; i < 32; i++) begin : g_cell
        localparam logic [N_BITS-1:0] RV = (i == int'(REG_GP)) ? GP_INIT :
                                           (i == int'(REG_SP)) ? SP_INIT : '0;
        logic en;

        assign en = RegWrite && (WriteRegister == reg_idx_t'(i));

        regfile_cell #(
            .N_BITS (N_BITS),
            .RST_VAL(RV)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .en   (en),
            .d    (WriteData),
            .q    (regs[i])
        );
    end

    logic bypass1, bypass2;

    // Bypass only when the write will actually land: not to $zero, not under reset.
    assign bypass1 = WRITE_FIRST && reset && RegWrite &&
                     (WriteRegister == ReadRegister1) && (ReadRegister1 != REG_ZERO);
    assign bypass2 = WRITE_FIRST && reset && RegWrite &&
                     (WriteRegister == ReadRegister2) && (ReadRegister2 != REG_ZERO);

    always_comb begin
        ReadData1 = regs[ReadRegister1];
        ReadData2 = regs[ReadRegister2];
        if (bypass1)
            ReadData1 = WriteData;
        if (bypass2)
            ReadData2 = WriteData;
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a read-before-write and a write-first
// instance share stimulus and are checked against a 32-entry reference model.
module tb_register_file;
    import register_file_pkg::*;

    localparam logic [31:0] SP_V = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_V = 32'h1000_8000;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] rd1_rb, rd2_rb, rd1_wf, rd2_wf;

    register_file #(.WRITE_FIRST(1'b0)) dut_rb (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_rb), .ReadData2(rd2_rb)
    );

    register_file #(.WRITE_FIRST(1'b1)) dut_wf (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_wf), .ReadData2(rd2_wf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rb1, rb2, wf1, wf2;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] model [32];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ra, input bit wf);
        if (ra == 5'd0)
            return 32'h0;
        if (wf && reset && RegWrite && WriteRegister == ra)
            return WriteData;
        return model[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++)
            model[i] = 32'h0;
        model[28] = GP_V;
        model[29] = SP_V;
    endtask

    // Drive one cycle of stimulus, queue the expectation, check before the edge.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
        exp_t e, o;
        reset         = rst;
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = ra1;
        ReadRegister2 = ra2;
        e.rb1 = model_read(ra1, 1'b0);
        e.rb2 = model_read(ra2, 1'b0);
        e.wf1 = model_read(ra1, 1'b1);
        e.wf2 = model_read(ra2, 1'b1);
        sb_q.push_back(e);
        @(negedge clk);
        o = sb_q.pop_front();
        chk("sb_rb_rd1", rd1_rb, o.rb1);
        chk("sb_rb_rd2", rd2_rb, o.rb2);
        chk("sb_wf_rd1", rd1_wf, o.wf1);
        chk("sb_wf_rd2", rd2_wf, o.wf2);
    endtask

    // Clock edge; the model commits whatever the inputs hold at the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset)
            model_reset();
        else if (RegWrite && WriteRegister != 5'd0)
            model[WriteRegister] = WriteData;
        #1;
    endtask

    initial begin
        logic [31:0] exp_v;
        logic [4:0]  wa, ra1, ra2;
        for (int i = 0; i < 32; i++)
            model[i] = 32'h0;
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;

        // Reset held for two edges, then sweep both ports.
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0); tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0); tick();
        for (int a = 0; a < 32; a++) begin
            cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            exp_v = (a == 28) ? GP_V : (a == 29) ? SP_V : 32'h0;
            chk("rst_sweep_rd1", rd1_rb, exp_v);
            exp_v = (31 - a == 28) ? GP_V : (31 - a == 29) ? SP_V : 32'h0;
            chk("rst_sweep_rd2", rd2_wf, exp_v);
            tick();
        end
        cyc(1'b1, 1'b0, 5'd0, 32'h0, REG_RA, REG_SP);
        chk("rst_ra", rd1_rb, 32'h0);
        chk("rst_sp", rd2_rb, SP_V);
        tick();

        // Back-to-back writes, then read.
        cyc(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0); tick();
        cyc(1'b1, 1'b1, 5'd9, 32'h0000_0001, 5'd0, 5'd0); tick();
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9);
        chk("wr_r8", rd1_rb, 32'hDEAD_BEEF);
        chk("wr_r9", rd2_rb, 32'h0000_0001);
        tick();
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
        chk("r10_untouched", rd1_rb, 32'h0);
        tick();

        // $zero is never written nor bypassed.
        cyc(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        chk("zero_wf_same", rd1_wf, 32'h0);
        chk("zero_rb_same", rd2_rb, 32'h0);
        tick();
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        chk("zero_rb_after", rd1_rb, 32'h0);
        chk("zero_wf_after", rd2_wf, 32'h0);
        tick();

        // Enable gating and same-cycle read/write.
        cyc(1'b1, 1'b0, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
        chk("gate_wf_nobypass", rd1_wf, 32'h0);
        tick();
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        chk("gate_r5", rd1_rb, 32'h0);
        tick();
        cyc(1'b1, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
        chk("same_rb_old", rd1_rb, 32'h0);
        chk("same_wf_new", rd2_wf, 32'h1234_5678);
        tick();
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        chk("same_after", rd2_rb, 32'h1234_5678);
        tick();

        // Reset overrides a pending write to $sp.
        cyc(1'b1, 1'b1, 5'd29, 32'h0000_0100, 5'd0, 5'd0); tick();
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd29, 5'd29);
        chk("sp_written", rd1_rb, 32'h0000_0100);
        tick();
        cyc(1'b0, 1'b1, 5'd29, 32'hAAAA_AAAA, 5'd29, 5'd29);
        chk("rstwr_wf_nobypass", rd1_wf, 32'h0000_0100);
        tick();
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd29, 5'd5);
        chk("rstwr_sp", rd1_rb, SP_V);
        chk("rstwr_r5", rd2_wf, 32'h0);
        tick();

        // Random regression against the model.
        for (int n = 0; n < 10000; n++) begin
            wa  = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), wa,
                $urandom(), ra1, ra2);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
